// File: rtl/fluxo_genius_n.sv
// Genius game engine: LFSR-generated one-hot sequence, autonomous LED playback,
// then checks the player's presses against it under an inactivity timeout.
module fluxo_genius_n #(
  parameter int          N         = 4,
  parameter int          W_END     = 4,
  parameter int          T_LED     = 2000,
  parameter int          T_APAGA   = 500,
  parameter int          T_INATIVO = 5000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             iniciar,
  input  logic             rapido,
  input  logic [N-1:0]     botoes,
  output logic [N-1:0]     leds,
  output logic             mostrando,
  output logic             jogada_feita,
  output logic             fim_rodada,
  output logic             timeout,
  output logic             ganhou,
  output logic             perdeu,
  output logic [W_END-1:0] rodada,
  output logic [W_END-1:0] db_indice,
  output logic [N-1:0]     db_memoria,
  output logic [3:0]       db_estado
);
  localparam int LOG2N  = $clog2(N);
  localparam int DEPTH  = 1 << W_END;
  localparam int T_MAX1 = (T_LED > T_APAGA) ? T_LED : T_APAGA;
  localparam int T_MAX  = (T_MAX1 > T_INATIVO) ? T_MAX1 : T_INATIVO;
  localparam int TW     = (T_MAX > 2) ? $clog2(T_MAX) : 1;

  localparam logic [TW-1:0] ON_LAST        = TW'(T_LED - 1);
  localparam logic [TW-1:0] ON_RAPIDO_LAST = TW'(T_LED / 2 - 1);
  localparam logic [TW-1:0] APAGA_LAST     = TW'(T_APAGA - 1);
  localparam logic [TW-1:0] INATIVO_LAST   = TW'(T_INATIVO - 1);

  typedef enum logic [3:0] {
    OCIOSO     = 4'd0,
    GERA       = 4'd1,
    MOSTRA_ON  = 4'd2,
    MOSTRA_OFF = 4'd3,
    ESPERA     = 4'd4,
    COMPARA    = 4'd5,
    GANHOU     = 4'd6,
    PERDEU     = 4'd7
  } estado_t;

  estado_t          estado, estado_n;
  logic [W_END-1:0] rodada_q, rodada_n;
  logic [W_END-1:0] indice, indice_n;
  logic [TW-1:0]    timer, timer_n;
  logic [N-1:0]     jogada, jogada_n;
  logic [15:0]      lfsr;
  logic             tem_q, rapido_q, rapido_n;
  logic             jogada_feita_n, fim_rodada_n, timeout_n;
  logic             mem_we;
  logic [N-1:0]     mem [DEPTH];

  logic          tem, press, correto, lfsr_fb;
  logic [N-1:0]  simbolo;
  logic [TW-1:0] on_last;

  assign tem     = |botoes;
  assign press   = tem & ~tem_q;
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign simbolo = {{(N-1){1'b0}}, 1'b1} << lfsr[LOG2N-1:0];
  assign on_last = rapido_q ? ON_RAPIDO_LAST : ON_LAST;
  // Memory is not reset, so the one-hot test guards against stale contents too.
  assign correto = (jogada != '0) && ((jogada & (jogada - 1'b1)) == '0) &&
                   (jogada == mem[indice]);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      estado       <= OCIOSO;
      rodada_q     <= '0;
      indice       <= '0;
      timer        <= '0;
      jogada       <= '0;
      tem_q        <= 1'b0;
      rapido_q     <= 1'b0;
      lfsr         <= LFSR_SEED;
      jogada_feita <= 1'b0;
      fim_rodada   <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      estado       <= estado_n;
      rodada_q     <= rodada_n;
      indice       <= indice_n;
      timer        <= timer_n;
      jogada       <= jogada_n;
      tem_q        <= tem;
      rapido_q     <= rapido_n;
      lfsr         <= {lfsr[14:0], lfsr_fb};
      jogada_feita <= jogada_feita_n;
      fim_rodada   <= fim_rodada_n;
      timeout      <= timeout_n;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[rodada_q] <= simbolo;
  end

  // Every state entry clears the timer; iniciar overrides all other transitions.
  always_comb begin
    estado_n       = estado;
    rodada_n       = rodada_q;
    indice_n       = indice;
    timer_n        = timer + 1'b1;
    jogada_n       = jogada;
    rapido_n       = rapido_q;
    jogada_feita_n = 1'b0;
    fim_rodada_n   = 1'b0;
    timeout_n      = 1'b0;
    mem_we         = 1'b0;
    if (iniciar) begin
      estado_n = GERA;
      rodada_n = '0;
      indice_n = '0;
      timer_n  = '0;
    end else begin
      case (estado)
        GERA: begin
          mem_we   = 1'b1;
          estado_n = MOSTRA_ON;
          indice_n = '0;
          timer_n  = '0;
          rapido_n = rapido;
        end
        MOSTRA_ON: begin
          if (timer == on_last) begin
            estado_n = MOSTRA_OFF;
            timer_n  = '0;
          end
        end
        MOSTRA_OFF: begin
          if (timer == APAGA_LAST) begin
            timer_n = '0;
            if (indice == rodada_q) begin
              estado_n = ESPERA;
              indice_n = '0;
            end else begin
              estado_n = MOSTRA_ON;
              indice_n = indice + 1'b1;
              rapido_n = rapido;
            end
          end
        end
        ESPERA: begin
          if (press) begin
            estado_n       = COMPARA;
            jogada_n       = botoes;
            jogada_feita_n = 1'b1;
            timer_n        = '0;
          end else if (timer == INATIVO_LAST) begin
            estado_n  = PERDEU;
            timeout_n = 1'b1;
            timer_n   = '0;
          end
        end
        COMPARA: begin
          timer_n = '0;
          if (!correto) begin
            estado_n = PERDEU;
          end else if (indice != rodada_q) begin
            estado_n = ESPERA;
            indice_n = indice + 1'b1;
          end else if (&rodada_q) begin
            estado_n     = GANHOU;
            fim_rodada_n = 1'b1;
          end else begin
            estado_n     = GERA;
            rodada_n     = rodada_q + 1'b1;
            fim_rodada_n = 1'b1;
          end
        end
        OCIOSO, GANHOU, PERDEU: timer_n = '0;
        default: begin
          estado_n = OCIOSO;
          timer_n  = '0;
        end
      endcase
    end
  end

  always_comb begin
    leds      = '0;
    mostrando = 1'b0;
    ganhou    = 1'b0;
    perdeu    = 1'b0;
    case (estado)
      OCIOSO, ESPERA: leds = botoes;
      MOSTRA_ON: begin
        leds      = mem[indice];
        mostrando = 1'b1;
      end
      MOSTRA_OFF: mostrando = 1'b1;
      GANHOU: begin
        leds   = '1;
        ganhou = 1'b1;
      end
      PERDEU: perdeu = 1'b1;
      default: ;
    endcase
  end

  assign rodada     = rodada_q;
  assign db_indice  = indice;
  assign db_memoria = mem[indice];
  assign db_estado  = estado;
endmodule

// File: doc/fluxo_genius_n.md
# fluxo_genius_n

Parametrised Genius game engine: datapath plus its own sequencing FSM. Generates a random one-hot sequence from an LFSR, plays it back autonomously on the LEDs, then checks the player's button presses against it with an inactivity timeout. Successor of the fixed 4-button, 16-step Genius datapath: width, depth and timings are parameters, and sequence generation, playback timing and win/lose decisions are internal. Sits between the debounced/synchronised button inputs and the board LEDs/displays.

## Interface
- N, 4: number of buttons/LEDs; power of two, 2..8
- W_END, 4: sequence address width; DEPTH = 2^W_END steps
- T_LED, 2000: cycles a step's LED is lit during playback
- T_APAGA, 500: cycles LEDs are dark between playback steps
- T_INATIVO, 5000: cycles without a press before timeout
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero

- clock  in  1  single clock, all state on rising edge
- reset_n  in  1  synchronous, active-low reset
- iniciar  in  1  start/restart game; sampled every cycle
- rapido  in  1  level; when 1, playback on-time is T_LED/2 (integer division)
- botoes  in  N  button levels, already synchronised
- leds  out  N  LED drive
- mostrando  out  1  high in MOSTRA_ON/MOSTRA_OFF
- jogada_feita  out  1  1-cycle pulse on rising edge of |botoes while in ESPERA
- fim_rodada  out  1  1-cycle pulse when a round is completed
- timeout  out  1  1-cycle pulse when inactivity expires
- ganhou  out  1  level, high in GANHOU
- perdeu  out  1  level, high in PERDEU
- rodada  out  W_END  current round (sequence length − 1)
- db_indice  out  W_END  current playback/compare index
- db_memoria  out  N  sequence element at db_indice
- db_estado  out  4  FSM state encoding

## Operation
- Storage: DEPTH×N register array, asynchronous read at db_indice, written only in GERA at address rodada.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle including OCIOSO. New symbol = 1 << lfsr[log2(N)−1:0].
- Edge detector: tem = |botoes; press = tem & ~tem_q; tem_q is registered every cycle.
- States:
  - OCIOSO: leds = botoes. iniciar → GERA with rodada=0, indice=0.
  - GERA (1 cycle): write symbol at rodada. → MOSTRA_ON, indice=0, timer=0.
  - MOSTRA_ON: leds = mem[indice]; after on-time cycles → MOSTRA_OFF, timer=0.
  - MOSTRA_OFF: leds = 0; after T_APAGA cycles, if indice==rodada → ESPERA (indice=0, timer=0), else indice+1 → MOSTRA_ON.
  - ESPERA: leds = botoes; timer counts. On press, botoes is registered into jogada and jogada_feita pulses → COMPARA. If timer reaches T_INATIVO−1 with no press → timeout pulse, → PERDEU.
  - COMPARA (1 cycle): correct = jogada one-hot and == mem[indice]. Wrong → PERDEU. Correct with indice<rodada → indice+1, timer=0, → ESPERA. Correct with indice==rodada: if rodada==DEPTH−1 → GANHOU, else rodada+1, fim_rodada pulse, → GERA.
  - GANHOU/PERDEU: leds = all ones / all zeros. Held until iniciar.
- A press with more than one button high is compared as given; it fails the one-hot check and sends the FSM to PERDEU.
- Button edges arriving outside ESPERA are ignored, but tem_q still updates. A button held from playback into ESPERA therefore does not register as a press.
- Round is completed on the final correct press. fim_rodada also pulses on the winning press.

## Timing
- Reset (reset_n=0 at an edge): state OCIOSO, rodada=0, indice=0, timer=0, tem_q=0, jogada=0, lfsr=LFSR_SEED, all pulses 0, ganhou=perdeu=mostrando=0. Memory contents are not reset.
- Reset mid-game takes effect at the next edge and overrides iniciar.
- iniciar in any non-reset state: → GERA with rodada=0 at the next edge. It has priority over all other transitions in that cycle.
- Press at edge k (tem rises) → jogada_feita high in cycle k+1, in COMPARA. The result state is entered at edge k+2. fim_rodada is high in the cycle after COMPARA.
- Playback of round r lasts exactly (r+1)·(on-time+T_APAGA) cycles, plus 1 cycle for GERA.
- rapido is sampled on entry to each MOSTRA_ON.
- Timer width is ceil(log2(max(T_LED,T_APAGA,T_INATIVO))). The timer never wraps: it is reset on every state entry.
- The index, with W_END bits, never exceeds rodada, so it never wraps.

## Test plan
Bench parameters: N=4, W_END=2, T_LED=4, T_APAGA=2, T_INATIVO=20.
- Reset: hold reset_n=0 for 3 cycles → state OCIOSO, rodada=0, ganhou=perdeu=0. With botoes=4'b0010, leds=4'b0010.
- Playback timing: pulse iniciar → 1 GERA cycle, leds=mem[0] for 4 cycles, then 0 for 2 cycles, then ESPERA. With rapido=1 the lit time is 2 cycles.
- Full win: pulse iniciar, then after each playback press the back-read correct sequence, releasing between presses → 3 fim_rodada pulses before GANHOU, plus 1 on entry to GANHOU. rodada=3 and leds=4'b1111 in GANHOU.
- Wrong or multi-button press: in round 0 press the complement of mem[0] → PERDEU 2 cycles after the edge. Repeat the game and press 4'b0011 → PERDEU.
- Timeout: enter ESPERA with no press → timeout pulse after 20 cycles, then PERDEU. A press at cycle 19 is accepted and restarts the timer.
- Held button / restart: hold a button through playback → no jogada_feita on entering ESPERA. Assert iniciar during MOSTRA_ON of round 2 → GERA next cycle with rodada=0.
